// File: rtl/shared_port_arbiter.sv
// shared_port_arbiter: round-robin grant of one single-ported resource with start pulse and watchdog release
package macros;
  function automatic int log_2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction
endpackage

module shared_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int IDX_W = macros::log_2(NUM_REQ),
  localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : macros::log_2(TIMEOUT_CYCLES) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               res_start,
  input  logic               res_done,
  output logic               timeout
);
  if (NUM_REQ < 2 || (NUM_REQ & (NUM_REQ - 1)) != 0) begin : g_bad_num_req
    $error("NUM_REQ must be a power of two and at least 2");
  end
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [IDX_W-1:0] ptr, base, cand, win;
  logic [CNT_W-1:0] cnt;
  logic expire, release_now, arb, found;
  always_comb begin
    expire = TIMEOUT_CYCLES != 0 && cnt == CNT_W'(TIMEOUT_CYCLES - 1) && !res_done;
    release_now = state == BUSY && (res_done || expire);
    arb = state == IDLE || release_now;
    base = release_now ? gnt_idx + IDX_W'(1) : ptr;
    found = 1'b0;
    win = '0;
    cand = '0;
    // the just-released requester lands last in the search because base starts one past it
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = base + IDX_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        win = cand;
      end
    end
    state_n = arb ? (found ? BUSY : IDLE) : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      gnt <= '0;
      gnt_idx <= '0;
      gnt_valid <= 1'b0;
      res_start <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      timeout <= release_now && expire;
      res_start <= arb && found;
      if (release_now) ptr <= base;
      if (arb) begin
        gnt <= found ? NUM_REQ'(1) << win : '0;
        gnt_idx <= found ? win : '0;
        gnt_valid <= found;
        cnt <= '0;
      end else begin
        cnt <= (&cnt) ? cnt : cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_shared_port_arbiter.sv
// tb_shared_port_arbiter: directed and random checks of shared_port_arbiter against a behavioural model
module tb_shared_port_arbiter;
  localparam int N = 4;
  localparam int TO = 8;
  logic clk, rst, res_done, gnt_valid, res_start, timeout;
  logic [N-1:0] req, gnt;
  logic [1:0] gnt_idx;
  int checks = 0;
  int errors = 0;
  shared_port_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .gnt_idx(gnt_idx),
    .gnt_valid(gnt_valid), .res_start(res_start), .res_done(res_done), .timeout(timeout)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int pick(input int p, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  int m_owner = -1;
  int m_ptr = 0;
  int m_age = 0;
  int m_w;
  bit m_start = 0;
  bit m_to = 0;
  bit m_wd;
  bit started = 0;
  always @(posedge clk) begin
    if (rst) begin
      started = 1;
      m_owner = -1;
      m_ptr = 0;
      m_age = 0;
      m_start = 0;
      m_to = 0;
    end else begin
      m_start = 0;
      m_to = 0;
      if (m_owner >= 0) begin
        m_wd = m_age == TO - 1 && !res_done;
        if (res_done || m_wd) begin
          m_ptr = (m_owner + 1) % N;
          m_to = m_wd;
          m_owner = -1;
        end else m_age++;
      end
      if (m_owner < 0) begin
        m_w = pick(m_ptr, req);
        if (m_w >= 0) begin
          m_owner = m_w;
          m_age = 0;
          m_start = 1;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (started) begin
      chk("model_gnt", gnt, m_owner >= 0 ? 32'd1 << m_owner : 32'd0);
      chk("model_idx", gnt_idx, m_owner >= 0 ? m_owner : 0);
      chk("model_valid", gnt_valid, m_owner >= 0);
      chk("model_start", res_start, m_start);
      chk("model_timeout", timeout, m_to);
    end
  end
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1;
    step();
    rst = 0;
  endtask
  task automatic done_pulse();
    res_done = 1;
    step();
    res_done = 0;
  endtask
  int seen[N];
  int budget;
  initial begin
    rst = 1; req = 0; res_done = 0;
    step(2);
    rst = 0;
    chk("rst_gnt", gnt, 0);
    chk("rst_valid", gnt_valid, 0);
    chk("rst_start", res_start, 0);
    chk("rst_timeout", timeout, 0);
    step(2);
    req = 4'b0100;
    step();
    chk("single_gnt", gnt, 4'b0100);
    chk("single_idx", gnt_idx, 2);
    chk("single_valid", gnt_valid, 1);
    chk("single_start", res_start, 1);
    step();
    chk("single_start_low", res_start, 0);
    req = 0;
    step();
    done_pulse();
    chk("single_rel_gnt", gnt, 0);
    chk("single_rel_valid", gnt_valid, 0);
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 2 * N; k++) begin
      budget = 0;
      while (!res_start && budget < 20) begin step(); budget++; end
      chk("rr_start_seen", res_start, 1);
      chk("rr_idx", gnt_idx, k % N);
      seen[gnt_idx]++;
      step();
      chk("rr_start_once", res_start, 0);
      step();
      done_pulse();
    end
    for (int i = 0; i < N; i++) chk("rr_fair", seen[i], 2);
    req = 0;
    step(3);
    do_reset();
    req = 4'b0010;
    step();
    chk("b2b_first", gnt_idx, 1);
    req = 4'b0011;
    step();
    done_pulse();
    chk("b2b_skip_idx", gnt_idx, 0);
    chk("b2b_no_idle", gnt_valid, 1);
    chk("b2b_start", res_start, 1);
    req = 4'b0010;
    step();
    done_pulse();
    chk("b2b_second", gnt_idx, 1);
    req = 0;
    done_pulse();
    chk("b2b_idle", gnt_valid, 0);
    do_reset();
    req = 4'b1000;
    step();
    chk("wd_idx", gnt_idx, 3);
    req = 0;
    for (int c = 1; c < TO; c++) begin
      step();
      chk("wd_quiet", timeout, 0);
    end
    step();
    chk("wd_pulse", timeout, 1);
    chk("wd_released", gnt_valid, 0);
    step();
    chk("wd_one_cycle", timeout, 0);
    req = 4'b1000;
    step();
    chk("wd2_idx", gnt_idx, 3);
    req = 0;
    step(TO - 1);
    done_pulse();
    chk("wd2_no_timeout", timeout, 0);
    chk("wd2_released", gnt_valid, 0);
    do_reset();
    req = 4'b0100;
    step();
    req = 0;
    step(3);
    chk("hold_gnt", gnt, 4'b0100);
    done_pulse();
    chk("hold_rel", gnt, 0);
    done_pulse();
    chk("idle_done_gnt", gnt, 0);
    chk("idle_done_start", res_start, 0);
    req = 4'b0010;
    step();
    chk("mid_idx", gnt_idx, 1);
    req = 0;
    do_reset();
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_valid", gnt_valid, 0);
    chk("mid_rst_start", res_start, 0);
    req = 4'b1111;
    step();
    chk("mid_rst_ptr", gnt_idx, 0);
    for (int c = 0; c < 2000; c++) begin
      req = N'($urandom);
      if ($urandom_range(0, 3) == 0) req = 0;
      res_done = $urandom_range(0, 5) == 0;
      rst = $urandom_range(0, 199) == 0;
      step();
    end
    rst = 0; req = 0; res_done = 0;
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
